vz_loader: RTL

VZ_LOADER -- requirements
Module: vz_loader

---
 rtl/vz_loader_if.sv | 22 ++
 rtl/vz_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vz_loader_if.sv
// vz_loader_if: hps_io download stream into the VZ loader and the loader's RAM write port.
interface vz_loader_if;
   logic        dn_download;
   logic        dn_wr;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic [7:0]  dn_index;
   logic        mem_wait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        mem_we;

   modport master (
      output dn_download, dn_wr, dn_addr, dn_data, dn_index, mem_wait,
      input  mem_addr, mem_dout, mem_we
   );

   modport slave (
      input  dn_download, dn_wr, dn_addr, dn_data, dn_index, mem_wait,
      output mem_addr, mem_dout, mem_we
   );
endinterface

// File: rtl/vz_loader.sv
// vz_loader: parses a VZ image from the hps_io download stream and writes its payload to RAM.
// Define VZ_LOADER_PTR_FIXUP_EN to patch the BASIC end / binary start pointers after loading.
module vz_loader #(
   parameter logic [7:0] VZ_INDEX = 8'd1,
   parameter int         HDR_LEN  = 24
) (
   input  logic        clk_sys,
   input  logic        reset,
   vz_loader_if.slave  bus,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  vz_type,
   output logic [15:0] vz_start,
   output logic [15:0] vz_end
);

   typedef enum logic [2:0] {
      IDLE = 3'd0, HDR = 3'd1, DATA = 3'd2, DRAIN = 3'd3, FIX = 3'd4, DONE = 3'd5, ERR = 3'd6
   } state_t;

   localparam logic [15:0] HDR_LEN16 = 16'(HDR_LEN);
   localparam logic [15:0] HDR_LAST  = 16'(HDR_LEN - 1);

   function automatic logic [7:0] magic_vzf(input logic [1:0] idx);
      case (idx)
         2'd0:    magic_vzf = 8'h56;
         2'd1:    magic_vzf = 8'h5A;
         2'd2:    magic_vzf = 8'h46;
         default: magic_vzf = 8'h30;
      endcase
   endfunction

   function automatic logic [7:0] magic_bin(input logic [1:0] idx);
      magic_bin = idx[1] ? 8'h00 : 8'h20;
   endfunction

   state_t      state_r, state_s;
   logic        dn_prev_r;
   logic        mag_a_r, mag_a_s, mag_b_r, mag_b_s;
   logic        skid_valid_r, skid_valid_s;
   logic [15:0] skid_addr_r, skid_addr_s;
   logic [7:0]  skid_data_r, skid_data_s;
   logic [1:0]  fix_idx_r, fix_idx_s;
   logic        mem_we_s, busy_s, done_s, err_s;
   logic [15:0] mem_addr_s, vz_start_s, vz_end_s, data_addr_s;
   logic [7:0]  mem_dout_s, vz_type_s;
   logic        start_s, fall_s, out_free_s, hdr_wr_s, data_wr_s, a_hit_s, b_hit_s;
   logic        magic_bad_s, hdr_last_s, overflow_s, drained_s, fix_type_s;

   assign start_s     = bus.dn_download & ~dn_prev_r & (bus.dn_index == VZ_INDEX);
   assign fall_s      = ~bus.dn_download & dn_prev_r;
   assign out_free_s  = ~bus.mem_we | ~bus.mem_wait;
   assign hdr_wr_s    = (state_r == HDR) & bus.dn_wr;
   assign data_wr_s   = (state_r == DATA) & bus.dn_wr;
   // Each magic flavour stays alive only while every byte so far has matched it.
   assign a_hit_s     = mag_a_r & (bus.dn_data == magic_vzf(bus.dn_addr[1:0]));
   assign b_hit_s     = mag_b_r & (bus.dn_data == magic_bin(bus.dn_addr[1:0]));
   assign magic_bad_s = hdr_wr_s & (bus.dn_addr < 16'd4) & ~a_hit_s & ~b_hit_s;
   assign hdr_last_s  = hdr_wr_s & (bus.dn_addr == HDR_LAST);
   assign overflow_s  = data_wr_s & ~out_free_s & skid_valid_r;
   assign drained_s   = ~skid_valid_r & out_free_s;
   assign fix_type_s  = (vz_type == 8'hF0) | (vz_type == 8'hF1);
   assign data_addr_s = vz_start + (bus.dn_addr - HDR_LEN16);

   // State register; strobe history resets high so a download already in flight is not restarted.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         dn_prev_r <= 1'b1;
      end else begin
         state_r   <= state_s;
         dn_prev_r <= bus.dn_download;
      end
   end

   // Next-state selection.
   always_comb begin
      state_s = state_r;
      if (start_s) begin
         state_s = HDR;
      end else begin
         case (state_r)
            IDLE:    state_s = IDLE;
            HDR:     state_s = (fall_s || magic_bad_s) ? ERR : (hdr_last_s ? DATA : HDR);
            DATA:    state_s = overflow_s ? ERR : (fall_s ? DRAIN : DATA);
`ifdef VZ_LOADER_PTR_FIXUP_EN
            DRAIN:   state_s = drained_s ? FIX : DRAIN;
`else
            DRAIN:   state_s = drained_s ? DONE : DRAIN;
`endif
            FIX:     state_s = (!fix_type_s || (fix_idx_r == 2'd2 && out_free_s)) ? DONE : FIX;
            DONE:    state_s = IDLE;
            ERR:     state_s = ERR;
            default: state_s = IDLE;
         endcase
      end
   end

   // Status flags for the state being entered.
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      err_s  = 1'b0;
      case (state_s)
         HDR, DATA, DRAIN, FIX: busy_s = 1'b1;
         DONE:                  done_s = 1'b1;
         ERR:                   err_s  = 1'b1;
         default:               busy_s = 1'b0;
      endcase
   end

   // Write queue (output register plus skid entry), header capture and pointer fixups.
   always_comb begin
      mem_we_s     = bus.mem_we;
      mem_addr_s   = bus.mem_addr;
      mem_dout_s   = bus.mem_dout;
      skid_valid_s = skid_valid_r;
      skid_addr_s  = skid_addr_r;
      skid_data_s  = skid_data_r;
      vz_type_s    = vz_type;
      vz_start_s   = vz_start;
      vz_end_s     = vz_end;
      mag_a_s      = mag_a_r;
      mag_b_s      = mag_b_r;
      fix_idx_s    = fix_idx_r;
      if (start_s || state_s == ERR) begin
         mem_we_s     = 1'b0;
         skid_valid_s = 1'b0;
         if (start_s) begin
            vz_type_s  = 8'h00;
            vz_start_s = 16'h0000;
            vz_end_s   = 16'h0000;
            mag_a_s    = 1'b1;
            mag_b_s    = 1'b1;
            fix_idx_s  = 2'd0;
         end else begin
            fix_idx_s  = fix_idx_r;
         end
      end else begin
         if (out_free_s) begin
            mem_we_s     = skid_valid_r;
            mem_addr_s   = skid_valid_r ? skid_addr_r : bus.mem_addr;
            mem_dout_s   = skid_valid_r ? skid_data_r : bus.mem_dout;
            skid_valid_s = 1'b0;
         end else begin
            mem_we_s     = bus.mem_we;
         end
         if (data_wr_s) begin
            vz_end_s = vz_end + 16'd1;
            if (out_free_s && !skid_valid_r) begin
               mem_we_s   = 1'b1;
               mem_addr_s = data_addr_s;
               mem_dout_s = bus.dn_data;
            end else begin
               skid_valid_s = 1'b1;
               skid_addr_s  = data_addr_s;
               skid_data_s  = bus.dn_data;
            end
         end else begin
            vz_end_s = vz_end;
         end
         if (hdr_wr_s) begin
            if (bus.dn_addr < 16'd4) begin
               mag_a_s = a_hit_s;
               mag_b_s = b_hit_s;
            end else begin
               mag_a_s = mag_a_r;
            end
            case (bus.dn_addr)
               16'd21:  vz_type_s = bus.dn_data;
               16'd22:  begin vz_start_s[7:0] = bus.dn_data;  vz_end_s[7:0] = bus.dn_data;  end
               16'd23:  begin vz_start_s[15:8] = bus.dn_data; vz_end_s[15:8] = bus.dn_data; end
               default: vz_type_s = vz_type;
            endcase
         end else begin
            vz_type_s = vz_type;
         end
         if (state_r == FIX && fix_type_s && out_free_s && fix_idx_r != 2'd2) begin
            mem_we_s = 1'b1;
            if (vz_type == 8'hF0) begin
               mem_addr_s = fix_idx_r[0] ? 16'h78FA : 16'h78F9;
               mem_dout_s = fix_idx_r[0] ? vz_end[15:8] : vz_end[7:0];
            end else begin
               mem_addr_s = fix_idx_r[0] ? 16'h788F : 16'h788E;
               mem_dout_s = fix_idx_r[0] ? vz_start[15:8] : vz_start[7:0];
            end
            fix_idx_s = fix_idx_r + 2'd1;
         end else begin
            fix_idx_s = fix_idx_r;
         end
      end
   end

   // Registered outputs and datapath state.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= 16'h0000;
         bus.mem_dout <= 8'h00;
         skid_valid_r <= 1'b0;
         skid_addr_r  <= 16'h0000;
         skid_data_r  <= 8'h00;
         vz_type      <= 8'h00;
         vz_start     <= 16'h0000;
         vz_end       <= 16'h0000;
         mag_a_r      <= 1'b0;
         mag_b_r      <= 1'b0;
         fix_idx_r    <= 2'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         bus.mem_we   <= mem_we_s;
         bus.mem_addr <= mem_addr_s;
         bus.mem_dout <= mem_dout_s;
         skid_valid_r <= skid_valid_s;
         skid_addr_r  <= skid_addr_s;
         skid_data_r  <= skid_data_s;
         vz_type      <= vz_type_s;
         vz_start     <= vz_start_s;
         vz_end       <= vz_end_s;
         mag_a_r      <= mag_a_s;
         mag_b_r      <= mag_b_s;
         fix_idx_r    <= fix_idx_s;
         busy         <= busy_s;
         done         <= done_s;
         err          <= err_s;
      end
   end

endmodule
